// File: rtl/result_checker.sv
// result_checker
//   Consumer end of the stimulus pipeline. It pops one expected entry
//   {expected[23:0], vec_addr[19:0]} from CHECK_FIFO and one DUT output vector
//   from RESULT_FIFO, then compares them under a programmable bitmask. For
//   each mismatch it writes a 4-word failure record through an Avalon-MM
//   write master, and it keeps saturating test and fail counters.
//
// Optional feature macro: RESULT_CHECKER_PASS_LOG_EN
//   When defined, passing compares also write a record (pass bit = 1,
//   diff word = 0). Pass and fail records share the slot space.
//
// Ports
//   clock, reset_n        system clock, synchronous active-low reset
//   clear                 zero counters/overflow, bitmask back to all ones
//   done                  idle with both FIFOs empty
//   cfifo_*               CHECK_FIFO read side (non-showahead)
//   rfifo_*               RESULT_FIFO read side (non-showahead)
//   sc_cmd, sc_data       stim command (1 = load bitmask), sc_ready = idle
//   mem_*                 Avalon-MM write master for failure records
//   test_count            vectors compared (saturating)
//   fail_count            mismatches found (saturating)
//   overflow              more failures than record slots
module result_checker #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int STF_WIDTH  = 24,
  parameter int CHF_WIDTH  = STF_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] RESULT_BASE = 20'h80000,
  parameter int MAX_FAILS  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  output logic                  done,
  input  logic [CHF_WIDTH-1:0]  cfifo_data,
  output logic                  cfifo_rdreq,
  input  logic                  cfifo_rdempty,
  input  logic [STF_WIDTH-1:0]  rfifo_data,
  output logic                  rfifo_rdreq,
  input  logic                  rfifo_rdempty,
  input  logic [SCC_WIDTH-1:0]  sc_cmd,
  input  logic [SCD_WIDTH-1:0]  sc_data,
  output logic                  sc_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  output logic [CNT_WIDTH-1:0]  test_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  overflow
);

  localparam int SLOT_WIDTH = $clog2(MAX_FAILS);
  localparam logic [CNT_WIDTH:0] MAX_FAILS_C = (CNT_WIDTH + 1)'(MAX_FAILS);
  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK = SCC_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, LATCH, CMP, WR0, WR1, WR2, WR3} state_t;

  state_t                state;
  logic [STF_WIDTH-1:0]  exp_reg;
  logic [STF_WIDTH-1:0]  dut_reg;
  logic [STF_WIDTH-1:0]  mask_reg;
  logic [ADDR_WIDTH-1:0] vaddr_reg;
  logic [DATA_WIDTH-1:0] diff_lo_reg;

  logic [STF_WIDTH-1:0]  diff;
  logic                  pop;
  logic                  want_rec;
  logic                  pass_bit;
  logic [CNT_WIDTH:0]    rec_total;
  logic [SLOT_WIDTH-1:0] slot;
  logic [ADDR_WIDTH-1:0] rec_base;
  logic [DATA_WIDTH-1:0] word0, word1, word2, word3;

`ifdef RESULT_CHECKER_PASS_LOG_EN
  logic [CNT_WIDTH-1:0]  pass_idx;
  logic                  pass_reg;

  assign want_rec  = 1'b1;
  assign pass_bit  = pass_reg;
  assign rec_total = {1'b0, fail_count} + {1'b0, pass_idx};
`else
  assign want_rec  = (diff != '0);
  assign pass_bit  = 1'b0;
  assign rec_total = {1'b0, fail_count};
`endif

  // The pop strobe has to be combinational: with non-showahead FIFOs the
  // data must be valid during LATCH, so the pop is issued in the IDLE cycle
  // that decides to start a compare. Gated by reset so no pop escapes then.
  assign pop         = reset_n & (state == IDLE) & ~cfifo_rdempty & ~rfifo_rdempty;
  assign cfifo_rdreq = pop;
  assign rfifo_rdreq = pop;

  assign done           = (state == IDLE) & cfifo_rdempty & rfifo_rdempty;
  assign sc_ready       = (state == IDLE);
  assign mem_byteenable = '1;

  assign diff = (dut_reg ^ exp_reg) & mask_reg;

  // Record count before this compare is the slot of the new record.
  assign slot     = rec_total[SLOT_WIDTH-1:0];
  assign rec_base = RESULT_BASE + ADDR_WIDTH'({slot, 2'b00});

  assign word0 = vaddr_reg[15:0];
  assign word1 = {vaddr_reg[19:16], pass_bit, 3'b000, dut_reg[23:16]};
  assign word2 = dut_reg[15:0];
  assign word3 = diff_lo_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      test_count    <= '0;
      fail_count    <= '0;
      overflow      <= 1'b0;
      mask_reg      <= '1;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      exp_reg       <= '0;
      dut_reg       <= '0;
      vaddr_reg     <= '0;
      diff_lo_reg   <= '0;
`ifdef RESULT_CHECKER_PASS_LOG_EN
      pass_idx      <= '0;
      pass_reg      <= 1'b0;
`endif
    end else begin
      // Bitmask: a command in the same cycle as clear wins (later assignment).
      if (clear) mask_reg <= '1;
      if (sc_cmd == CMD_BITMASK) mask_reg <= STF_WIDTH'(sc_data);

      case (state)
        IDLE: begin
          if (pop) state <= LATCH;
        end
        LATCH: begin
          exp_reg   <= cfifo_data[CHF_WIDTH-1 -: STF_WIDTH];
          vaddr_reg <= cfifo_data[ADDR_WIDTH-1:0];
          dut_reg   <= rfifo_data;
          state     <= CMP;
        end
        CMP: begin
          diff_lo_reg <= diff[DATA_WIDTH-1:0];
          if (~&test_count) test_count <= test_count + CNT_WIDTH'(1);
          if (diff != '0) begin
            if (~&fail_count) fail_count <= fail_count + CNT_WIDTH'(1);
          end
`ifdef RESULT_CHECKER_PASS_LOG_EN
          else if (~&pass_idx) begin
            pass_idx <= pass_idx + CNT_WIDTH'(1);
          end
          pass_reg <= (diff == '0);
`endif
          if (want_rec && (rec_total < MAX_FAILS_C)) begin
            state         <= WR0;
            mem_write     <= 1'b1;
            mem_address   <= rec_base;
            mem_writedata <= word0;
          end else begin
            if (want_rec) overflow <= 1'b1;
            state <= IDLE;
          end
        end
        WR0: begin
          if (!mem_waitrequest) begin
            state         <= WR1;
            mem_address   <= mem_address + ADDR_WIDTH'(1);
            mem_writedata <= word1;
          end
        end
        WR1: begin
          if (!mem_waitrequest) begin
            state         <= WR2;
            mem_address   <= mem_address + ADDR_WIDTH'(1);
            mem_writedata <= word2;
          end
        end
        WR2: begin
          if (!mem_waitrequest) begin
            state         <= WR3;
            mem_address   <= mem_address + ADDR_WIDTH'(1);
            mem_writedata <= word3;
          end
        end
        WR3: begin
          if (!mem_waitrequest) begin
            state     <= IDLE;
            mem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // clear overrides any increment made by CMP in this cycle.
      if (clear) begin
        test_count <= '0;
        fail_count <= '0;
        overflow   <= 1'b0;
`ifdef RESULT_CHECKER_PASS_LOG_EN
        pass_idx   <= '0;
`endif
      end
    end
  end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Consumer end of the stimulus pipeline. Pops expected-result entries (expected vector plus vector address) from the CHECK_FIFO read side, and pops matching DUT output vectors from the RESULT_FIFO filled by the DUT interface.
- Compares each pair under the output bitmask programmed over the CHECK <=> STIM command interface.
- Writes a 4-word failure record per mismatch to memory through an Avalon MM write master into mem_if, and keeps test and fail counters.

Parameters:
- ADDR_WIDTH, 20, memory word address width; also the width of the vector address field in the CHECK_FIFO.
- DATA_WIDTH, 16, memory data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- STF_WIDTH, 24, vector width.
- CHF_WIDTH, STF_WIDTH+ADDR_WIDTH, CHECK_FIFO word width.
- SCC_WIDTH, 5, stim command width.
- SCD_WIDTH, 24, stim command data width.
- RESULT_BASE, 20'h80000, word address of failure record 0.
- MAX_FAILS, 1024, number of record slots; a power of 2.
- CNT_WIDTH, 16, width of the test and fail counters.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- clear  in  1  one-cycle pulse: zero counters and overflow, return bitmask to all ones
- done  out  1  checker idle and both FIFOs empty
- cfifo_data  in  CHF_WIDTH  {expected[23:0], vec_addr[19:0]}
- cfifo_rdreq  out  1  CHECK_FIFO pop
- cfifo_rdempty  in  1  CHECK_FIFO empty
- rfifo_data  in  STF_WIDTH  DUT output vector
- rfifo_rdreq  out  1  RESULT_FIFO pop
- rfifo_rdempty  in  1  RESULT_FIFO empty
- sc_cmd  in  SCC_WIDTH  stim command (00000 idle, 00001 bitmask)
- sc_data  in  SCD_WIDTH  command payload
- sc_ready  out  1  checker able to accept a command without disturbing a compare
- mem_address  out  ADDR_WIDTH  write address
- mem_byteenable  out  BE_WIDTH  constant all ones
- mem_write  out  1  write strobe
- mem_writedata  out  DATA_WIDTH  write data
- mem_waitrequest  in  1  slave stall
- test_count  out  CNT_WIDTH  vectors compared
- fail_count  out  CNT_WIDTH  mismatches found
- overflow  out  1  more than MAX_FAILS failures seen

Behaviour:
- Reset, when reset_n is low at a rising clock edge:
  - state IDLE
  - test_count, fail_count and overflow are 0
  - bitmask is all ones
  - every strobe output is 0
  - A reset taken during a record write abandons the write at once; a partial record is acceptable.
- FIFOs are non-showahead: data is valid on the cycle after the rdreq cycle.
- States:
  - IDLE: when cfifo_rdempty=0 and rfifo_rdempty=0, assert cfifo_rdreq and rfifo_rdreq in the same cycle and go to LATCH. A pop never happens with either FIFO empty.
  - LATCH: register exp, vaddr and dut; go to CMP.
  - CMP:
    - diff = (dut ^ exp) & bitmask.
    - test_count += 1, saturating at all ones.
    - If diff = 0, go to IDLE.
    - Otherwise fail_count += 1, saturating. If fail_count < MAX_FAILS before the increment, go to WR0; otherwise set overflow and go to IDLE.
  - WR0..WR3: mem_write = 1; mem_address = RESULT_BASE + (slot<<2) + n, where slot = fail_count-1 truncated to log2(MAX_FAILS) bits. Data per word:
    - WR0 data = vaddr[15:0]
    - WR1 data = {vaddr[19:16], pass=0, 3'b0, dut[23:16]}
    - WR2 data = dut[15:0]
    - WR3 data = diff[15:0]
    - Hold address and data until a cycle with mem_waitrequest = 0, then advance. From WR3 go to IDLE.
- Throughput: a pass costs 3 cycles; a fail costs 3 + 4 cycles plus stalls.
- Bitmask command:
  - sc_cmd = 00001 on any cycle latches sc_data into bitmask, whatever the state.
  - The new value first applies to a CMP in a later cycle.
  - sc_ready = (state == IDLE).
  - Other sc_cmd codes are ignored.
- clear:
  - Honoured on any cycle and takes priority over a CMP increment in the same cycle.
  - Does not abort an in-flight record write.
  - clear together with a bitmask command: the command value wins.
- done = (state == IDLE) & cfifo_rdempty & rfifo_rdempty.
- An imbalance where one FIFO is non-empty and the other empty is not an error: wait in IDLE.

Optional Feature:
- Macro: RESULT_CHECKER_PASS_LOG_EN.
- Defined:
  - Passing compares also write a record, from CMP to WR0, with the WR1 pass bit (bit 11) = 1 and WR3 = 0.
  - Records use a separate pass_idx counter that shares the slot space: slot = (fail_count+pass_idx-1) mod MAX_FAILS.
  - overflow sets once total records exceed MAX_FAILS.
- Undefined: behaviour as above and pass_idx is absent.

Test Plan:
- Reset, then push cfifo {24'hABCDEF, 20'h00010} and rfifo 24'hABCDEF -> test_count=1, fail_count=0, no mem_write, done=1 after 3 cycles.
- Push exp 24'h000000 with vaddr 20'h12345, dut 24'h800001 -> fail_count=1; writes at 80000..80003 of 2345, 1080, 0001, 0001.
- Issue bitmask 24'h7FFFFE and then the same vectors as above -> pass, no write. Also send bitmask in the same cycle as a CMP -> that CMP uses the old mask.
- Hold mem_waitrequest=1 for 5 cycles during WR1 -> address 80001 and its data stay stable, there are exactly 4 accepted writes, and no FIFO pop occurs meanwhile.
- Use MAX_FAILS=4 and 6 failing vectors -> 4 records written, fail_count=6, overflow=1; then pulse clear -> counters=0, overflow=0, bitmask=FFFFFF.
- Fill only cfifo -> no pop and done=0. Assert reset_n low mid-WR2 -> outputs return to reset values on the next edge.
